// File: rtl/fifo_wptr_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO write/read pointer controllers.
// Functions work on a fixed wide vector; callers zero-extend and truncate.
package fifo_wptr_ctrl_pkg;
  localparam int DEF_ADDR_WIDTH  = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int PTR_MAX         = 16;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
endpackage

// File: rtl/fifo_wptr_ctrl_ptr_sync.sv
// Multi-bit flop-chain synchroniser; latency STAGES edges, no backpressure.
// Only safe for Gray-coded buses where at most one bit changes per update.
module ptr_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Async FIFO write-pointer controller: status registered, visible 1 edge after a write,
// SYNC_STAGES+1 edges after a read-pointer change; writes while full are dropped and flagged.
module fifo_wptr_ctrl
  import fifo_wptr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wclken,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  woverflow
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin, wbin_next;
  logic [PW-1:0] wgray, wgray_next;
  logic [PW-1:0] rsync, rbin;
  logic [PW-1:0] full_ptr;
  logic [PW-1:0] wcount_next;
  logic          wfull_next;
  logic          walmost_full_next;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rsync (
    .clk (clk),
    .rst (rst),
    .d   (rptr_gray),
    .q   (rsync)
  );

  // Gated by rst so the RAM never sees a write strobe while the pointer is held in reset.
  assign wclken = winc & ~wfull & rst;

  assign wbin_next  = wbin + PW'(wclken);
  assign wgray_next = PW'(bin2gray(PTR_MAX'(wbin_next)));
  assign rbin       = PW'(gray2bin(PTR_MAX'(rsync)));

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_ptr          = rsync ^ (PW'(3) << (PW - 2));
  assign wfull_next        = (wgray_next == full_ptr);
  assign wcount_next       = wbin_next - rbin;
  assign walmost_full_next = (wcount_next >= af_thresh);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin         <= '0;
      wgray        <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wgray        <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wcount       <= wcount_next;
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (ovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

  assign waddr     = wbin[ADDR_WIDTH-1:0];
  assign wptr_gray = wgray;
endmodule
